// File: rtl/frame_scheduler.sv
// ---------------------------------------------------------------------------
// frame_scheduler
//
// Purpose:
//   Detects the start of each video frame from the falling edge of the
//   active-low vertical sync and, once every FRAME_DIV+1 frames, runs a fixed
//   update sequence: paddle, then ball, then score. Each task is requested
//   with a one-hot strobe and the sequence waits for that task's done strobe
//   before moving on. Frame starts that land while a sequence is still running
//   are counted as overruns. They never restart the sequence.
//
// Parameters:
//   FRAME_DIV    number of skipped frames between update sequences (0 = every frame)
//   TIMEOUT_CYC  ack watchdog limit in vga_clk cycles (watchdog build only)
//
// Ports:
//   vga_clk      in   1   pixel clock, the only clock
//   sys_rst      in   1   synchronous active-high reset
//   vga_vs       in   1   active-low vertical sync
//   pause        in   1   inhibits launch of new update sequences
//   upd_ack      in   3   per-task done strobes (bit0 paddle, bit1 ball, bit2 score)
//   upd_req      out  3   one-hot task request, same bit mapping as upd_ack
//   frame_tick   out  1   one-cycle pulse per frame start
//   busy         out  1   high while an update sequence is in progress
//   frame_cnt    out  16  frame start count (wraps)
//   overrun_cnt  out  8   frame starts seen while busy (saturates at 255)
//   err_timeout  out  1   sticky ack-watchdog expiry flag
//
// Build option:
//   SCHED_TIMEOUT_EN  when defined, a watchdog forces each request state to
//                     advance after TIMEOUT_CYC cycles without an ack and sets
//                     err_timeout. When undefined, request states wait
//                     indefinitely and err_timeout is tied low.
// ---------------------------------------------------------------------------
module frame_scheduler #(
  parameter logic [1:0]  FRAME_DIV   = 2'd0,
  parameter logic [15:0] TIMEOUT_CYC = 16'd1000
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        vga_vs,
  input  logic        pause,
  input  logic [2:0]  upd_ack,
  output logic [2:0]  upd_req,
  output logic        frame_tick,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [7:0]  overrun_cnt,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_PADDLE,
    REQ_BALL,
    REQ_SCORE,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       vs_q;
  logic [1:0] div_cnt;
  logic       frame_start;
  logic       launch;
  logic       ack_hit;
  logic       wd_expired;
  logic       req_done;

  // Request strobe that goes with a given state. The outputs are registered
  // from the next state, so they change on the same edge as the state.
  function automatic logic [2:0] req_code(input state_t s);
    case (s)
      REQ_PADDLE: return 3'b001;
      REQ_BALL:   return 3'b010;
      REQ_SCORE:  return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  // A frame starts where the registered sync was high and the live sync is low.
  // vs_q resets high, so a sync that is already low when reset releases still
  // counts as a frame start on the first edge.
  assign frame_start = vs_q & ~vga_vs;
  assign launch      = frame_start && (div_cnt == FRAME_DIV);

  // Only the ack bit that belongs to the current request state matters.
  always_comb begin
    ack_hit = 1'b0;
    case (state)
      REQ_PADDLE: ack_hit = upd_ack[0];
      REQ_BALL:   ack_hit = upd_ack[1];
      REQ_SCORE:  ack_hit = upd_ack[2];
      default:    ack_hit = 1'b0;
    endcase
  end

`ifdef SCHED_TIMEOUT_EN
  logic [15:0] watchdog;

  // The watchdog holds the number of cycles already spent in the current
  // request state. The request expires on the edge that ends cycle
  // TIMEOUT_CYC, so each unacknowledged request lasts exactly TIMEOUT_CYC cycles.
  // An ack on that same edge wins and does not raise the error.
  assign wd_expired = (state == REQ_PADDLE || state == REQ_BALL || state == REQ_SCORE)
                      && !ack_hit && (watchdog == TIMEOUT_CYC - 16'd1);
`else
  logic unused_timeout;

  assign wd_expired     = 1'b0;
  assign err_timeout    = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  assign req_done = ack_hit | wd_expired;

  // Next-state logic for the update sequence. A frame start outside IDLE
  // never changes the state. It only feeds the overrun counter.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (launch && !pause) state_nxt = REQ_PADDLE;
      REQ_PADDLE: if (req_done) state_nxt = REQ_BALL;
      REQ_BALL:   if (req_done) state_nxt = REQ_SCORE;
      REQ_SCORE:  if (req_done) state_nxt = DONE;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // All state and outputs are registered here. upd_req and busy are derived
  // from the next state, so the first request and busy appear in the same
  // cycle as frame_tick. The divider and frame counter advance on every frame
  // start, whether or not that start launches a sequence.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      vs_q        <= 1'b1;
      div_cnt     <= 2'd0;
      upd_req     <= 3'b000;
      frame_tick  <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= 16'd0;
      overrun_cnt <= 8'd0;
`ifdef SCHED_TIMEOUT_EN
      err_timeout <= 1'b0;
      watchdog    <= 16'd0;
`endif
    end else begin
      vs_q       <= vga_vs;
      frame_tick <= frame_start;
      state      <= state_nxt;
      upd_req    <= req_code(state_nxt);
      busy       <= (state_nxt != IDLE);
      if (frame_start) begin
        frame_cnt <= frame_cnt + 16'd1;
        div_cnt   <= (div_cnt == FRAME_DIV) ? 2'd0 : div_cnt + 2'd1;
        if (state != IDLE && overrun_cnt != 8'hFF)
          overrun_cnt <= overrun_cnt + 8'd1;
      end
`ifdef SCHED_TIMEOUT_EN
      if (state_nxt != state)
        watchdog <= 16'd0;
      else if (state == REQ_PADDLE || state == REQ_BALL || state == REQ_SCORE)
        watchdog <= watchdog + 16'd1;
      if (wd_expired)
        err_timeout <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_frame_scheduler
//
// Purpose:
//   Self-checking bench for frame_scheduler. Two instances share the clock,
//   reset, sync and pause inputs. dut0 runs with FRAME_DIV=0 and dut2 runs
//   with FRAME_DIV=2, and each has its own ack inputs. A behavioural model
//   tracks every output of both instances. It describes the update sequence as
//   a position number (0 idle, 1..3 task, 4 done) and uses plain integer
//   counters.
//   Scenario tasks add directed checks for the headline behaviours.
//   The watchdog scenario is compiled only when SCHED_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_frame_scheduler;

  localparam int TO = 16;

  logic        vga_clk = 1'b0;
  logic        sys_rst;
  logic        vga_vs;
  logic        pause;
  logic [2:0]  ack0, ack2;
  logic [2:0]  req0, req2;
  logic        tick0, tick2, busy0, busy2, err0, err2;
  logic [15:0] fc0, fc2;
  logic [7:0]  ov0, ov2;

  int n_cmp = 0;
  int n_bad = 0;
  bit auto0, auto2;

  // Behavioural model state, indexed by instance (0 = dut0, 1 = dut2).
  int fd [2] = '{0, 2};
  int m_pos [2];
  int m_div [2];
  int m_fc  [2];
  int m_ov  [2];
  int m_age [2];
  bit m_tick [2];
  bit m_err  [2];
  bit m_vs;

  always #5 vga_clk = ~vga_clk;

  frame_scheduler #(.FRAME_DIV(2'd0), .TIMEOUT_CYC(16'd16)) dut0 (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .vga_vs(vga_vs), .pause(pause),
    .upd_ack(ack0), .upd_req(req0), .frame_tick(tick0), .busy(busy0),
    .frame_cnt(fc0), .overrun_cnt(ov0), .err_timeout(err0));

  frame_scheduler #(.FRAME_DIV(2'd2), .TIMEOUT_CYC(16'd16)) dut2 (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .vga_vs(vga_vs), .pause(pause),
    .upd_ack(ack2), .upd_req(req2), .frame_tick(tick2), .busy(busy2),
    .frame_cnt(fc2), .overrun_cnt(ov2), .err_timeout(err2));

  // Advance the model by one clock edge, using the inputs the DUTs sample.
  task automatic model_step();
    bit fall, launch;
    logic [2:0] a;
    if (sys_rst) begin
      m_vs = 1'b1;
      for (int d = 0; d < 2; d++) begin
        m_pos[d] = 0; m_div[d] = 0; m_fc[d] = 0; m_ov[d] = 0;
        m_age[d] = 0; m_tick[d] = 0; m_err[d] = 0;
      end
    end else begin
      fall = m_vs && !vga_vs;
      m_vs = vga_vs;
      for (int d = 0; d < 2; d++) begin
        a = (d == 0) ? ack0 : ack2;
        m_tick[d] = fall;
        launch = 0;
        if (fall) begin
          m_fc[d] = (m_fc[d] + 1) % 65536;
          if (m_pos[d] != 0 && m_ov[d] < 255) m_ov[d]++;
          if (m_div[d] == fd[d]) begin m_div[d] = 0; launch = 1; end
          else m_div[d]++;
        end
        if (m_pos[d] == 0) begin
          if (launch && !pause) begin m_pos[d] = 1; m_age[d] = 0; end
        end else if (m_pos[d] == 4) begin
          m_pos[d] = 0;
        end else begin
          m_age[d]++;
          if (a[m_pos[d] - 1]) begin m_pos[d]++; m_age[d] = 0; end
`ifdef SCHED_TIMEOUT_EN
          else if (m_age[d] >= TO) begin m_err[d] = 1; m_pos[d]++; m_age[d] = 0; end
`endif
        end
      end
    end
  endtask

  function automatic logic [29:0] exp_vec(input int d);
    logic [2:0] r;
    r = 3'b000;
    if (m_pos[d] >= 1 && m_pos[d] <= 3) r = 3'(1 << (m_pos[d] - 1));
    return {r, m_tick[d], m_pos[d] != 0, 16'(m_fc[d]), 8'(m_ov[d]), m_err[d]};
  endfunction

  function automatic logic [29:0] obs_vec(input int d);
    if (d == 0) return {req0, tick0, busy0, fc0, ov0, err0};
    return {req2, tick2, busy2, fc2, ov2, err2};
  endfunction

  // One clock: auto-acks answer the request currently shown, the model steps
  // on the inputs as they stand at the falling edge, and outputs are sampled
  // 1 time unit after the rising edge.
  task automatic tick_clk();
    @(negedge vga_clk);
    if (auto0) ack0 = req0;
    if (auto2) ack2 = req2;
    model_step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; vga_vs = 1'b1; pause = 1'b0; ack0 = 3'b000; ack2 = 3'b000;
    repeat (2) tick_clk();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    auto0 = 0; auto2 = 0;
    sys_rst = 1'b1; vga_vs = 1'b1; pause = 1'b0; ack0 = 3'b000; ack2 = 3'b000;
    repeat (3) tick_clk();
    n_cmp++;
    if (obs_vec(0) !== 30'h0) begin
      n_bad++; $display("[TB] FAIL reset_state: got %h expected %h", obs_vec(0), 30'h0);
    end
    sys_rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick_clk();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_bad++; $display("[TB] FAIL reset_model dut%0d: got %h expected %h", d, obs_vec(d), exp_vec(d));
        end
      end
    end
    n_cmp++;
    if ({tick0, req0, busy0, fc0} !== 21'h0) begin
      n_bad++; $display("[TB] FAIL idle_after_reset: got %h expected %h", {tick0, req0, busy0, fc0}, 21'h0);
    end
    // Sync already low when reset releases: first edge is a frame start.
    sys_rst = 1'b1; vga_vs = 1'b0;
    repeat (2) tick_clk();
    sys_rst = 1'b0;
    tick_clk();
    n_cmp++;
    if ({tick0, req0, fc0} !== {1'b1, 3'b001, 16'd1}) begin
      n_bad++; $display("[TB] FAIL release_low_vs: got %h expected %h", {tick0, req0, fc0}, {1'b1, 3'b001, 16'd1});
    end
    vga_vs = 1'b1; auto0 = 1;
    for (int i = 0; i < 10; i++) begin
      tick_clk();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_bad++; $display("[TB] FAIL release_model dut%0d: got %h expected %h", d, obs_vec(d), exp_vec(d));
        end
      end
    end
  endtask

  task automatic test_single_frame();
    logic [2:0]  last;
    logic [11:0] hist;
    int age, nchg;
    bit prev_done, saw_done;
    auto0 = 0; auto2 = 1;
    do_reset();
    last = 3'b000; hist = 12'h0; age = 0; nchg = 0; prev_done = 0; saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      vga_vs = (i < 2) ? 1'b0 : 1'b1;
      ack0 = (req0 != 3'b000 && age == 2) ? req0 : 3'b000;
      tick_clk();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_bad++; $display("[TB] FAIL single_model dut%0d: got %h expected %h", d, obs_vec(d), exp_vec(d));
        end
      end
      if (req0 != last) begin
        age = 0; nchg++; hist = {hist[8:0], req0};
      end else if (req0 != 3'b000) begin
        age++;
      end
      if (prev_done) begin
        n_cmp++;
        if (busy0 !== 1'b0) begin
          n_bad++; $display("[TB] FAIL busy_after_done: got %b expected %b", busy0, 1'b0);
        end
      end
      prev_done = (req0 == 3'b000 && busy0 == 1'b1);
      saw_done  = saw_done | prev_done;
      last = req0;
    end
    n_cmp++;
    if ({nchg[3:0], hist, saw_done, fc0} !== {4'd4, 12'h2A0, 1'b1, 16'd1}) begin
      n_bad++; $display("[TB] FAIL req_sequence: got changes=%0d hist=%h done=%b frames=%0d expected changes=4 hist=2a0 done=1 frames=1",
                        nchg, hist, saw_done, fc0);
    end
  endtask

  task automatic test_frame_div();
    auto0 = 1; auto2 = 1;
    do_reset();
    for (int f = 1; f <= 6; f++) begin
      for (int c = 0; c < 10; c++) begin
        vga_vs = (c == 0) ? 1'b0 : 1'b1;
        tick_clk();
        for (int d = 0; d < 2; d++) begin
          n_cmp++;
          if (obs_vec(d) !== exp_vec(d)) begin
            n_bad++; $display("[TB] FAIL div_model dut%0d: got %h expected %h", d, obs_vec(d), exp_vec(d));
          end
        end
        if (c == 0) begin
          n_cmp++;
          if ({tick2, busy2} !== {1'b1, logic'(f % 3 == 0)}) begin
            n_bad++; $display("[TB] FAIL div_launch frame%0d: got %b expected %b", f, {tick2, busy2}, {1'b1, logic'(f % 3 == 0)});
          end
        end
      end
    end
    n_cmp++;
    if (fc2 !== 16'd6) begin
      n_bad++; $display("[TB] FAIL div_frame_cnt: got %0d expected 6", fc2);
    end
  endtask

  task automatic test_overrun();
    int k;
    auto0 = 0; auto2 = 1;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 6; c++) begin
        vga_vs = (c == 0) ? 1'b0 : 1'b1;
        tick_clk();
        for (int d = 0; d < 2; d++) begin
          n_cmp++;
          if (obs_vec(d) !== exp_vec(d)) begin
            n_bad++; $display("[TB] FAIL overrun_model dut%0d: got %h expected %h", d, obs_vec(d), exp_vec(d));
          end
        end
      end
      n_cmp++;
      if (req0 !== 3'b001) begin
        n_bad++; $display("[TB] FAIL overrun_hold: got %b expected 001", req0);
      end
    end
    n_cmp++;
    if ({ov0, fc0} !== {8'd2, 16'd3}) begin
      n_bad++; $display("[TB] FAIL overrun_counts: got ov=%0d fc=%0d expected ov=2 fc=3", ov0, fc0);
    end
    auto0 = 1; k = 0;
    while (busy0 && k < 20) begin tick_clk(); k++; end
    n_cmp++;
    if (busy0 !== 1'b0) begin
      n_bad++; $display("[TB] FAIL overrun_drain: got busy=%b expected 0", busy0);
    end
  endtask

  task automatic test_overrun_saturate();
    int k;
    auto0 = 0; auto2 = 1;
    do_reset();
    for (int f = 0; f < 260; f++) begin
      for (int c = 0; c < 2; c++) begin
        vga_vs = (c == 0) ? 1'b0 : 1'b1;
        tick_clk();
        for (int d = 0; d < 2; d++) begin
          n_cmp++;
          if (obs_vec(d) !== exp_vec(d)) begin
            n_bad++; $display("[TB] FAIL sat_model dut%0d: got %h expected %h", d, obs_vec(d), exp_vec(d));
          end
        end
      end
    end
    n_cmp++;
    if ({ov0, fc0, req0} !== {8'd255, 16'd260, 3'b001}) begin
      n_bad++; $display("[TB] FAIL overrun_saturate: got ov=%0d fc=%0d req=%b expected ov=255 fc=260 req=001", ov0, fc0, req0);
    end
    auto0 = 1; k = 0;
    while (busy0 && k < 20) begin tick_clk(); k++; end
    n_cmp++;
    if (busy0 !== 1'b0) begin
      n_bad++; $display("[TB] FAIL sat_drain: got busy=%b expected 0", busy0);
    end
  endtask

  task automatic test_pause();
    int k;
    bit seen_score;
    auto0 = 1; auto2 = 1;
    do_reset();
    pause = 1'b1; vga_vs = 1'b0;
    tick_clk();
    n_cmp++;
    if ({tick0, busy0, req0, fc0} !== {1'b1, 1'b0, 3'b000, 16'd1}) begin
      n_bad++; $display("[TB] FAIL pause_drop: got %h expected %h", {tick0, busy0, req0, fc0}, {1'b1, 1'b0, 3'b000, 16'd1});
    end
    vga_vs = 1'b1;
    repeat (3) tick_clk();
    n_cmp++;
    if ({busy0, req0} !== 4'b0000) begin
      n_bad++; $display("[TB] FAIL pause_idle: got %b expected 0000", {busy0, req0});
    end
    // Launch, then raise pause mid-sequence: the sequence must still finish.
    pause = 1'b0; vga_vs = 1'b0;
    tick_clk();
    pause = 1'b1; vga_vs = 1'b1;
    k = 0; seen_score = 0;
    while (busy0 && k < 10) begin
      tick_clk();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_bad++; $display("[TB] FAIL pause_model dut%0d: got %h expected %h", d, obs_vec(d), exp_vec(d));
        end
      end
      if (req0 == 3'b100) seen_score = 1;
      k++;
    end
    n_cmp++;
    if ({busy0, seen_score} !== 2'b01) begin
      n_bad++; $display("[TB] FAIL pause_midseq: got busy=%b score_seen=%b expected busy=0 score_seen=1", busy0, seen_score);
    end
    pause = 1'b0;
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int len [3];
    bit seen_ball;
    auto0 = 0; auto2 = 0;
    do_reset();
    len = '{0, 0, 0}; seen_ball = 0;
    vga_vs = 1'b0;
    tick_clk();
    n_cmp++;
    if ({req0, err0} !== 4'b0010) begin
      n_bad++; $display("[TB] FAIL timeout_start: got %b expected 0010", {req0, err0});
    end
    if (req0 == 3'b001) len[0]++;
    vga_vs = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick_clk();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_bad++; $display("[TB] FAIL timeout_model dut%0d: got %h expected %h", d, obs_vec(d), exp_vec(d));
        end
      end
      if (req0 == 3'b001) len[0]++;
      if (req0 == 3'b010) len[1]++;
      if (req0 == 3'b100) len[2]++;
      if (req0 == 3'b010 && !seen_ball) begin
        seen_ball = 1;
        n_cmp++;
        if (err0 !== 1'b1) begin
          n_bad++; $display("[TB] FAIL timeout_err: got %b expected 1", err0);
        end
      end
    end
    n_cmp++;
    if (len[0] != TO || len[1] != TO || len[2] != TO || busy0 !== 1'b0 || err0 !== 1'b1) begin
      n_bad++; $display("[TB] FAIL timeout_lengths: got %0d/%0d/%0d busy=%b err=%b expected %0d each busy=0 err=1",
                        len[0], len[1], len[2], busy0, err0, TO);
    end
  endtask
`endif

  task automatic test_random();
    auto0 = 0; auto2 = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) vga_vs = ~vga_vs;
      pause   = ($urandom_range(0, 7) == 0);
      ack0    = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      ack2    = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      sys_rst = ($urandom_range(0, 499) == 0);
      tick_clk();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_vec(d) !== exp_vec(d)) begin
          n_bad++; $display("[TB] FAIL random_model dut%0d cycle %0d: got %h expected %h", d, i, obs_vec(d), exp_vec(d));
        end
      end
    end
    sys_rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_frame_div();
    test_overrun();
    test_overrun_saturate();
    test_pause();
`ifdef SCHED_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
